// File: rtl/stream_upsizer_flushable.sv
// stream_upsizer_flushable: packs Ratio narrow beats into one wide word, drops partial/held words on flush_i.
// Optional macro STREAM_UPSIZER_LAST_EN adds last_i (early word close) and keep_o (filled-slot mask).
module stream_upsizer_flushable #(
   parameter int InWidth = 8,
   parameter int Ratio   = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic [InWidth-1:0]       data_i,
   output logic                     valid_o,
   input  logic                     ready_i,
`ifdef STREAM_UPSIZER_LAST_EN
   input  logic                     last_i,
   output logic [Ratio-1:0]         keep_o,
`endif
   output logic [InWidth*Ratio-1:0] data_o
);
   localparam int OutWidth = InWidth*Ratio;
   localparam int CntWidth = $clog2(Ratio);
   localparam int AccWidth = OutWidth-InWidth;

   if (Ratio < 2) begin : g_bad_ratio
      $error("stream_upsizer_flushable: Ratio must be >= 2");
   end

   logic [AccWidth-1:0] acc_q, acc_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic [OutWidth-1:0] out_q, out_d, word, ext;
   logic                out_valid_q, out_valid_d;
   logic                close, accept;

`ifdef STREAM_UPSIZER_LAST_EN
   logic [Ratio-1:0] keep_q, keep_d;
   assign close  = (cnt_q == CntWidth'(Ratio-1)) || last_i;
   assign keep_o = keep_q;
   always_comb begin
      keep_d = keep_q;
      for (int i = 0; i < Ratio; i++)
         if (accept && close) keep_d[i] = (i <= int'(cnt_q));
   end
`else
   assign close = (cnt_q == CntWidth'(Ratio-1));
`endif

   // Only the beat that closes a word has to wait for the output register.
   assign ready_o     = !flush_i && (!close || !out_valid_q || ready_i);
   assign accept      = valid_i && ready_o;
   assign cnt_d       = flush_i ? '0 : !accept ? cnt_q : close ? '0 : cnt_q + 1'b1;
   assign out_valid_d = flush_i ? 1'b0 : (accept && close) ? 1'b1 : (out_valid_q && !ready_i);
   assign out_d       = (accept && close) ? word : out_q;
   assign valid_o     = out_valid_q;
   assign data_o      = out_q;

   // Slots above the closing beat are zeroed so stale accumulator bytes never leak out.
   always_comb begin
      ext   = {{InWidth{1'b0}}, acc_q};
      word  = '0;
      acc_d = acc_q;
      for (int i = 0; i < Ratio; i++) begin
         if (i < int'(cnt_q)) word[i*InWidth +: InWidth] = ext[i*InWidth +: InWidth];
         else if (i == int'(cnt_q)) word[i*InWidth +: InWidth] = data_i;
      end
      for (int i = 0; i < Ratio-1; i++)
         if (accept && !close && i == int'(cnt_q)) acc_d[i*InWidth +: InWidth] = data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
`ifdef STREAM_UPSIZER_LAST_EN
         keep_q      <= '0;
`endif
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
`ifdef STREAM_UPSIZER_LAST_EN
         keep_q      <= keep_d;
`endif
      end
   end

`ifndef COMMON_CELLS_ASSERTS_OFF
   flush_with_valid_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(flush_i && valid_i))
      else $error("stream_upsizer_flushable: valid_i during flush_i, beat dropped");
`endif
endmodule

// File: tb/tb_stream_upsizer_flushable.sv
// tb_stream_upsizer_flushable: directed + randomized bench against a queue-based word-assembly model.
module tb_stream_upsizer_flushable;
   localparam int W = 8;
   localparam int R = 4;

   logic clk_i = 0, rst_ni = 1, flush_i = 0, valid_i = 0, ready_i = 0;
   logic [W-1:0] data_i = 0;
   logic ready_o, valid_o;
   logic [W*R-1:0] data_o;
   logic lst;
   int total = 0, bad = 0;

`ifdef STREAM_UPSIZER_LAST_EN
   logic last_i = 0;
   logic [R-1:0] keep_o;
   assign lst = last_i;
`else
   assign lst = 1'b0;
`endif

   stream_upsizer_flushable #(.InWidth(W), .Ratio(R)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
      .valid_o(valid_o), .ready_i(ready_i),
`ifdef STREAM_UPSIZER_LAST_EN
      .last_i(last_i), .keep_o(keep_o),
`endif
      .data_o(data_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(string n, logic [63:0] a, logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
      end
   endtask

   // Model: beats of the open word in a queue, plus one held output word.
   logic [W-1:0] part[$];
   logic m_valid = 0;
   logic [W*R-1:0] m_word = 0;
   logic [R-1:0] m_keep = 0;

   function automatic logic m_ready();
      return !flush_i && !((part.size() == R-1 || lst) && m_valid && !ready_i);
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         part.delete(); m_valid = 0; m_word = 0; m_keep = 0;
      end else if (flush_i) begin
         part.delete(); m_valid = 0;
      end else begin : upd
         bit acc;
         acc = valid_i && m_ready();
         if (m_valid && ready_i) m_valid = 0;
         if (acc) begin
            part.push_back(data_i);
            if (part.size() == R || lst) begin
               m_word = 0; m_keep = 0;
               foreach (part[k]) begin m_word[k*W +: W] = part[k]; m_keep[k] = 1; end
               m_valid = 1;
               part.delete();
            end
         end
      end
   end

   always @(negedge clk_i) begin
      chk("ready_o", 64'(ready_o), 64'(m_ready()));
      chk("valid_o", 64'(valid_o), 64'(m_valid));
      chk("data_o", 64'(data_o), 64'(m_word));
`ifdef STREAM_UPSIZER_LAST_EN
      chk("keep_o", 64'(keep_o), 64'(m_keep));
`endif
   end

   task automatic cyc(bit v, logic [W-1:0] d, bit r, bit f = 0, bit l = 0);
      valid_i = v; data_i = d; ready_i = r; flush_i = f;
`ifdef STREAM_UPSIZER_LAST_EN
      last_i = l;
`endif
      @(posedge clk_i); #1;
   endtask

   initial begin
      #1 rst_ni = 0;
      #1;
      chk("rst valid_o", 64'(valid_o), 64'd0);
      chk("rst data_o", 64'(data_o), 64'd0);
      chk("rst ready_o", 64'(ready_o), 64'd1);
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1;
      // basic word
      cyc(1, 8'h11, 1); cyc(1, 8'h22, 1); cyc(1, 8'h33, 1); cyc(1, 8'h44, 1);
      chk("word1 valid", 64'(valid_o), 64'd1);
      chk("word1 data", 64'(data_o), 64'h44332211);
      chk("model word1", 64'(m_word), 64'h44332211);
      cyc(0, 0, 1);
      chk("word1 one cycle", 64'(valid_o), 64'd0);
      // back-to-back
      for (int i = 1; i <= 8; i++) begin
         chk("b2b ready", 64'(ready_o), 64'd1);
         cyc(1, W'(i), 1);
         if (i == 4) chk("b2b word a", 64'(data_o), 64'h04030201);
         if (i == 8) chk("b2b word b", 64'(data_o), 64'h08070605);
      end
      cyc(0, 0, 1);
      // stall on completing beat
      cyc(1, 8'h11, 0); cyc(1, 8'h12, 0); cyc(1, 8'h13, 0); cyc(1, 8'h14, 0);
      cyc(1, 8'h21, 0); cyc(1, 8'h22, 0); cyc(1, 8'h23, 0);
      valid_i = 1; data_i = 8'h24; #1;
      chk("stall ready", 64'(ready_o), 64'd0);
      cyc(1, 8'h24, 0); cyc(1, 8'h24, 0);
      chk("stall data", 64'(data_o), 64'h14131211);
      chk("stall valid", 64'(valid_o), 64'd1);
      cyc(1, 8'h24, 1);
      chk("refill valid", 64'(valid_o), 64'd1);
      chk("refill data", 64'(data_o), 64'h24232221);
      cyc(0, 0, 1);
      // flush mid-word
      cyc(1, 8'h31, 1); cyc(1, 8'h32, 1); cyc(0, 0, 0, 1);
      chk("flush valid", 64'(valid_o), 64'd0);
      cyc(1, 8'hA1, 1); cyc(1, 8'hA2, 1); cyc(1, 8'hA3, 1); cyc(1, 8'hA4, 1);
      chk("post flush word", 64'(data_o), 64'hA4A3A2A1);
      cyc(0, 0, 1);
`ifdef STREAM_UPSIZER_LAST_EN
      cyc(1, 8'h01, 1, 0, 0); cyc(1, 8'h02, 1, 0, 1);
      chk("last data", 64'(data_o), 64'h00000201);
      chk("last keep", 64'(keep_o), 64'b0011);
      cyc(1, 8'h05, 1); cyc(1, 8'h06, 1); cyc(1, 8'h07, 1); cyc(1, 8'h08, 1);
      chk("after last data", 64'(data_o), 64'h08070605);
      chk("after last keep", 64'(keep_o), 64'b1111);
      cyc(0, 0, 1);
`endif
      // async reset with a held word and a partial word
      cyc(1, 8'h51, 0); cyc(1, 8'h52, 0); cyc(1, 8'h53, 0); cyc(1, 8'h54, 0);
      cyc(1, 8'h61, 0); cyc(1, 8'h62, 0);
      valid_i = 0;
      #2 rst_ni = 0;
      #1;
      chk("async rst valid", 64'(valid_o), 64'd0);
      chk("async rst data", 64'(data_o), 64'd0);
      @(posedge clk_i); #1 rst_ni = 1;
      cyc(1, 8'h71, 1); cyc(1, 8'h72, 1); cyc(1, 8'h73, 1); cyc(1, 8'h74, 1);
      chk("post rst word", 64'(data_o), 64'h74737271);
      cyc(0, 0, 1);
      // random traffic
      for (int n = 0; n < 3000; n++) begin : rnd
         bit f, v, r, l;
         f = ($urandom_range(0, 49) == 0);
         v = !f && ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) != 0);
         l = ($urandom_range(0, 5) == 0);
         cyc(v, W'($urandom), r, f, l);
      end
      cyc(0, 0, 1); cyc(0, 0, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
